// File: rtl/reg_bank_arbiter_if.sv
// Bus bundle between the requesters and the register-bank arbiter.
// Handshake: a requester raises req[i] with its data on wr_data and keeps
// both stable until it sees grant[i] high for one cycle after an edge. That
// grant is the write acknowledge, and q then holds the captured data.
// lock[i] is only looked at together with req[i].
interface reg_bank_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       lock;
  logic [NUM_REQ*WIDTH-1:0] wr_data;
  logic [NUM_REQ-1:0]       grant;
  logic [WIDTH-1:0]         q;
  logic                     q_valid;
  logic [2:0]               owner;
  logic                     locked;

  modport master (
    output req, lock, wr_data,
    input  grant, q, q_valid, owner, locked
  );

  modport slave (
    input  req, lock, wr_data,
    output grant, q, q_valid, owner, locked
  );
endinterface

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter and write sequencer for a shared register bank.
// One capture per clock: the winner's data is loaded into q, and the winner
// gets a one-cycle registered grant.
// Optional burst lock is enabled with the macro RBA_LOCK_EN. When the macro
// is undefined, the lock bus is ignored and every edge arbitrates.
module reg_bank_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  reg_bank_arbiter_if.slave bus,
  output logic              o_dbg_state
);

  logic [WIDTH-1:0]   r_q, w_q_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic               r_q_valid, w_q_valid_nxt;
  logic [2:0]         r_owner, w_owner_nxt;
  logic [2:0]         r_rr_ptr, w_rr_ptr_nxt;

  logic               w_any_req;
  logic               w_hi_found;
  logic [2:0]         w_hi_win, w_lo_win, w_win;
  logic [WIDTH-1:0]   w_win_data;
  logic               w_win_lock;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [2:0] idx);
    onehot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (idx == 3'(k)) onehot[k] = 1'b1;
    end
  endfunction

  function automatic logic [2:0] wrap_inc(input logic [2:0] idx);
    wrap_inc = (idx == 3'(NUM_REQ - 1)) ? 3'd0 : idx + 3'd1;
  endfunction

  // Winner search: the lowest active index at or above rr_ptr, else the lowest active index overall
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_win   = '0;
    w_lo_win   = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (bus.req[j] && (3'(j) >= r_rr_ptr)) begin
        w_hi_win   = 3'(j);
        w_hi_found = 1'b1;
      end
      if (bus.req[j]) w_lo_win = 3'(j);
    end
    w_win     = w_hi_found ? w_hi_win : w_lo_win;
    w_any_req = |bus.req;
  end

  // Winner data/lock mux
  always_comb begin
    w_win_data = '0;
    w_win_lock = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_win == 3'(k)) begin
        w_win_data = bus.wr_data[k*WIDTH +: WIDTH];
        w_win_lock = bus.lock[k];
      end
    end
  end

`ifdef RBA_LOCK_EN
  typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

  state_t       r_state, w_state_nxt;
  logic [3:0]   r_burst_cnt, w_burst_nxt;
  logic [WIDTH-1:0] w_own_data;
  logic         w_own_req, w_own_lock, w_hold;

  // Current owner's request/lock/data mux
  always_comb begin
    w_own_data = '0;
    w_own_req  = 1'b0;
    w_own_lock = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r_owner == 3'(k)) begin
        w_own_data = bus.wr_data[k*WIDTH +: WIDTH];
        w_own_req  = bus.req[k];
        w_own_lock = bus.lock[k];
      end
    end
    w_hold = (r_state == S_LOCKED) && w_own_req && w_own_lock &&
             (r_burst_cnt < 4'(MAX_BURST));
  end

  // Next state and capture: keep the burst, or release and arbitrate in the same edge.
  // During a burst rr_ptr is already owner+1, so the release scan naturally
  // starts after the former owner.
  always_comb begin
    w_state_nxt   = r_state;
    w_burst_nxt   = r_burst_cnt;
    w_q_nxt       = r_q;
    w_grant_nxt   = '0;
    w_q_valid_nxt = 1'b0;
    w_owner_nxt   = r_owner;
    w_rr_ptr_nxt  = r_rr_ptr;
    if (w_hold) begin
      w_q_nxt       = w_own_data;
      w_grant_nxt   = onehot(r_owner);
      w_q_valid_nxt = 1'b1;
      w_burst_nxt   = r_burst_cnt + 4'd1;
    end else begin
      w_state_nxt = S_IDLE;
      w_burst_nxt = 4'd0;
      if (w_any_req) begin
        w_q_nxt       = w_win_data;
        w_grant_nxt   = onehot(w_win);
        w_q_valid_nxt = 1'b1;
        w_owner_nxt   = w_win;
        w_rr_ptr_nxt  = wrap_inc(w_win);
        if (w_win_lock) begin
          w_state_nxt = S_LOCKED;
          w_burst_nxt = 4'd1;
        end
      end
    end
  end

  // State register and burst counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_burst_cnt <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_burst_cnt <= w_burst_nxt;
    end
  end

  assign bus.locked  = (r_state == S_LOCKED);
  assign o_dbg_state = r_state;
`else
  logic w_unused_lock;
  assign w_unused_lock = w_win_lock ^ (^bus.lock);

  // Plain round-robin capture on every edge with an active request
  always_comb begin
    w_q_nxt       = r_q;
    w_grant_nxt   = '0;
    w_q_valid_nxt = 1'b0;
    w_owner_nxt   = r_owner;
    w_rr_ptr_nxt  = r_rr_ptr;
    if (w_any_req) begin
      w_q_nxt       = w_win_data;
      w_grant_nxt   = onehot(w_win);
      w_q_valid_nxt = 1'b1;
      w_owner_nxt   = w_win;
      w_rr_ptr_nxt  = wrap_inc(w_win);
    end
  end

  assign bus.locked  = 1'b0;
  assign o_dbg_state = 1'b0;
`endif

  // Register bank, acknowledge and rotation pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q       <= '0;
      r_grant   <= '0;
      r_q_valid <= 1'b0;
      r_owner   <= 3'd0;
      r_rr_ptr  <= 3'd0;
    end else begin
      r_q       <= w_q_nxt;
      r_grant   <= w_grant_nxt;
      r_q_valid <= w_q_valid_nxt;
      r_owner   <= w_owner_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
    end
  end

  assign bus.q       = r_q;
  assign bus.grant   = r_grant;
  assign bus.q_valid = r_q_valid;
  assign bus.owner   = r_owner;

endmodule
